// File: rtl/ethernet_pkg.sv
// ============================================================================
// Module  : ethernet_pkg
// Brief   : Shared types for the uplink failover controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ethernet_pkg;

    typedef enum logic [1:0] {
        LINK_NONE       = 2'd0,
        LINK_BASER      = 2'd1,
        LINK_BASET      = 2'd2,
        LINK_DRAIN_TO_R = 2'd3
    } linksel_state_t;

    // Selection pattern {sel_baser, sel_baset} driven while in a given state.
    function automatic logic [1:0] sel_of(input linksel_state_t s);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            LINK_BASER:      r = 2'b10;
            LINK_BASET:      r = 2'b01;
            LINK_DRAIN_TO_R: r = 2'b01;
            default:         r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/link_holdoff_debouncer.sv
// ============================================================================
// Module  : link_holdoff_debouncer
// Brief   : Declares a link stable after HOLDOFF_CYCLES consecutive raw-up cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module link_holdoff_debouncer #(
    parameter int HOLDOFF_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_up,
    output logic stable
);

    localparam int             CW     = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0]  C_HOLD = CW'(HOLDOFF_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!raw_up) begin
            cnt_d = '0;
        end else if (cnt_q != C_HOLD) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by raw_up so a drop is never masked by the saturated count.
    assign stable = raw_up && (cnt_q == C_HOLD);

endmodule

`default_nettype wire

// File: rtl/ethernet_link_failover_controller.sv
// ============================================================================
// Module  : ethernet_link_failover_controller
// Brief   : Sequenced baseR/baseT uplink selection with holdoff, drain and aborts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ethernet_link_failover_controller
    import ethernet_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 250000,
    parameter int DRAIN_TIMEOUT  = 4096,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   baser_link_up,
    input  logic                   baset_link_up,
    input  logic                   rx_start,
    input  logic                   rx_end,
    input  logic                   tx_start,
    input  logic                   tx_end,
    output logic                   sel_baser,
    output logic                   sel_baset,
    output logic                   link_up,
    output logic                   rx_abort,
    output logic                   tx_abort,
    output logic [COUNT_WIDTH-1:0] failover_count
);

    localparam int             TW           = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TW-1:0]  C_DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);

    logic baser_stable;
    logic baset_stable;

    link_holdoff_debouncer #(
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_baser_holdoff (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_up (baser_link_up),
        .stable (baser_stable)
    );

    link_holdoff_debouncer #(
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_baset_holdoff (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_up (baset_link_up),
        .stable (baset_stable)
    );

    linksel_state_t        state_q, state_d;
    logic                  sel_baser_q, sel_baser_d;
    logic                  sel_baset_q, sel_baset_d;
    logic                  rx_abort_q, rx_abort_d;
    logic                  tx_abort_q, tx_abort_d;
    logic                  rx_busy_q, rx_busy_d;
    logic                  tx_busy_q, tx_busy_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                  cut;
    logic                  changed;
    logic [1:0]            sel_next;

    always_comb begin
        state_d = state_q;
        cut     = 1'b0;
        timer_d = '0;
        case (state_q)
            LINK_NONE: begin
                if (baser_stable) begin
                    state_d = LINK_BASER;
                end else if (baset_stable) begin
                    state_d = LINK_BASET;
                end
            end
            LINK_BASET: begin
                if (!baset_link_up) begin
                    cut     = 1'b1;
                    state_d = baser_stable ? LINK_BASER : LINK_NONE;
                end else if (baser_stable) begin
                    state_d = LINK_DRAIN_TO_R;
                end
            end
            LINK_DRAIN_TO_R: begin
                // Losing both links at once must land in NONE, never via BASER.
                if (!baset_link_up) begin
                    cut     = 1'b1;
                    state_d = baser_stable ? LINK_BASER : LINK_NONE;
                end else if (!baser_link_up) begin
                    state_d = LINK_BASET;
                end else if (!rx_busy_q && !tx_busy_q) begin
                    state_d = LINK_BASER;
                end else if (timer_q == C_DRAIN_LAST) begin
                    cut     = 1'b1;
                    state_d = LINK_BASER;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LINK_BASER: begin
                if (!baser_link_up) begin
                    cut     = 1'b1;
                    state_d = baset_stable ? LINK_BASET : LINK_NONE;
                end
            end
            default: begin
                state_d = LINK_NONE;
            end
        endcase

        sel_next    = sel_of(state_d);
        sel_baser_d = sel_next[1];
        sel_baset_d = sel_next[0];
        changed     = ({sel_baser_d, sel_baset_d} != {sel_baser_q, sel_baset_q});

        rx_abort_d = cut && rx_busy_q;
        tx_abort_d = cut && tx_busy_q;

        // A start in the same cycle as an end wins: the new frame is in flight.
        if (changed) begin
            rx_busy_d = 1'b0;
            tx_busy_d = 1'b0;
        end else begin
            rx_busy_d = rx_start ? 1'b1 : (rx_end ? 1'b0 : rx_busy_q);
            tx_busy_d = tx_start ? 1'b1 : (tx_end ? 1'b0 : tx_busy_q);
        end

        count_d = count_q;
        if (changed && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LINK_NONE;
            sel_baser_q <= 1'b0;
            sel_baset_q <= 1'b0;
            rx_abort_q  <= 1'b0;
            tx_abort_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
            timer_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_baser_q <= sel_baser_d;
            sel_baset_q <= sel_baset_d;
            rx_abort_q  <= rx_abort_d;
            tx_abort_q  <= tx_abort_d;
            rx_busy_q   <= rx_busy_d;
            tx_busy_q   <= tx_busy_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
        end
    end

    assign sel_baser      = sel_baser_q;
    assign sel_baset      = sel_baset_q;
    assign link_up        = sel_baser_q | sel_baset_q;
    assign rx_abort       = rx_abort_q;
    assign tx_abort       = tx_abort_q;
    assign failover_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ethernet_link_failover_controller.sv
// ============================================================================
// Module  : tb_ethernet_link_failover_controller
// Brief   : Randomized check of the failover controller against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ethernet_link_failover_controller;

    localparam int H  = 100;
    localparam int T  = 64;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          baser_link_up, baset_link_up;
    logic          rx_start, rx_end, tx_start, tx_end;
    logic          sel_baser, sel_baset, link_up, rx_abort, tx_abort;
    logic [CW-1:0] failover_count;

    always #5 clk = ~clk;

    ethernet_link_failover_controller #(
        .HOLDOFF_CYCLES (H),
        .DRAIN_TIMEOUT  (T),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .baser_link_up  (baser_link_up),
        .baset_link_up  (baset_link_up),
        .rx_start       (rx_start),
        .rx_end         (rx_end),
        .tx_start       (tx_start),
        .tx_end         (tx_end),
        .sel_baser      (sel_baser),
        .sel_baset      (sel_baset),
        .link_up        (link_up),
        .rx_abort       (rx_abort),
        .tx_abort       (tx_abort),
        .failover_count (failover_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which link is selected (0 none, 1 baseR, 2 baseT), whether a
    // handover to baseR is pending, and how long each raw link has been up.
    int m_upr, m_upt, m_sel, m_age, m_cnt;
    bit m_drain, m_rxb, m_txb, m_rxa, m_txa;
    bit no_end;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sr, st, cut, ndrain;
        int nsel;
        if (!rst_n) begin
            m_upr = 0; m_upt = 0; m_sel = 0; m_age = 0; m_cnt = 0;
            m_drain = 0; m_rxb = 0; m_txb = 0; m_rxa = 0; m_txa = 0;
            return;
        end
        sr     = baser_link_up && (m_upr >= H);
        st     = baset_link_up && (m_upt >= H);
        cut    = 0;
        nsel   = m_sel;
        ndrain = 0;
        if (m_sel == 0) begin
            if (sr) nsel = 1;
            else if (st) nsel = 2;
        end else if (m_sel == 1) begin
            if (!baser_link_up) begin cut = 1; nsel = st ? 2 : 0; end
        end else if (!m_drain) begin
            if (!baset_link_up) begin cut = 1; nsel = sr ? 1 : 0; end
            else if (sr) begin ndrain = 1; m_age = 0; end
        end else begin
            if (!baset_link_up) begin cut = 1; nsel = sr ? 1 : 0; end
            else if (!baser_link_up) ndrain = 0;
            else if (!m_rxb && !m_txb) nsel = 1;
            else if (m_age == T - 1) begin cut = 1; nsel = 1; end
            else begin ndrain = 1; m_age++; end
        end
        m_rxa = cut && m_rxb;
        m_txa = cut && m_txb;
        if (nsel != m_sel) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_rxb = 0;
            m_txb = 0;
        end else begin
            if (rx_start) m_rxb = 1; else if (rx_end) m_rxb = 0;
            if (tx_start) m_txb = 1; else if (tx_end) m_txb = 0;
        end
        m_sel   = nsel;
        m_drain = ndrain;
        m_upr   = baser_link_up ? ((m_upr < H) ? m_upr + 1 : H) : 0;
        m_upt   = baset_link_up ? ((m_upt < H) ? m_upt + 1 : H) : 0;
    endtask

    task automatic compare_all();
        check("sel_baser", 32'(sel_baser), 32'(m_sel == 1));
        check("sel_baset", 32'(sel_baset), 32'(m_sel == 2));
        check("link_up", 32'(link_up), 32'(m_sel != 0));
        check("rx_abort", 32'(rx_abort), 32'(m_rxa));
        check("tx_abort", 32'(tx_abort), 32'(m_txa));
        check("failover_count", 32'(failover_count), 32'(m_cnt));
    endtask

    task automatic cycle();
        @(negedge clk);
        rx_start = ($urandom_range(0, 7) == 0);
        tx_start = ($urandom_range(0, 7) == 0);
        rx_end   = no_end ? 1'b0 : ($urandom_range(0, 7) == 0);
        tx_end   = no_end ? 1'b0 : ($urandom_range(0, 7) == 0);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        baser_link_up = 1'b0; baset_link_up = 1'b0;
        rx_start = 1'b0; rx_end = 1'b0; tx_start = 1'b0; tx_end = 1'b0;
        no_end = 1'b0;
        run(3);
        rst_n = 1'b1;

        // baseT comes up alone and gets selected after the holdoff.
        run(7);
        baset_link_up = 1'b1;
        run(150);

        // baseR becomes stable while frames never finish: drain times out.
        no_end = 1'b1;
        baser_link_up = 1'b1;
        run(H + T + 10);
        no_end = 1'b0;
        run(20);

        // baseR drops mid-frame with baseT stable: abort and fall back.
        no_end = 1'b1;
        run(10);
        baser_link_up = 1'b0;
        run(5);
        no_end = 1'b0;

        // baseR returns; drain completes when traffic goes idle.
        baser_link_up = 1'b1;
        run(H + 40);

        // Both links drop together.
        baser_link_up = 1'b0;
        baset_link_up = 1'b0;
        run(5);

        // Flapping baseR never reaches the holdoff.
        for (int i = 0; i < 8; i++) begin
            baser_link_up = ~baser_link_up;
            run(50);
        end
        baser_link_up = 1'b0;
        run(5);

        // Reset asserted mid-frame must not emit aborts.
        baser_link_up = 1'b1;
        run(H + 10);
        no_end = 1'b1;
        run(10);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        no_end = 1'b0;
        run(H + 10);

        // Free-running random link behaviour.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 249) == 0) baser_link_up = ~baser_link_up;
            if ($urandom_range(0, 249) == 0) baset_link_up = ~baset_link_up;
            if ($urandom_range(0, 99) == 0) no_end = ~no_end;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
